// File: rtl/ipml_pkt_fifo_v1_0_eth.sv
// rtl/ipml_pkt_fifo_v1_0_eth.sv - single-clock Ethernet packet FIFO with per-word end-of-frame flag
// ETH_PKT_FIFO_STORE_FWD_EN defined: store-and-forward with commit/drop; undefined: cut-through.
module ipml_pkt_fifo_v1_0_eth #(
    parameter int c_DATA_WIDTH       = 8,
    parameter int c_DEPTH_WIDTH      = 11,
    parameter int c_ALMOST_FULL_NUM  = 2040,
    parameter int c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [c_DATA_WIDTH-1:0]  wr_data,
    input  logic                     wr_en,
    input  logic                     wr_last,
    input  logic                     wr_drop,
    output logic                     wr_full,
    output logic                     almost_full,
    output logic [c_DEPTH_WIDTH:0]   wr_water_level,
    output logic                     ovf_drop,
    input  logic                     rd_en,
    output logic [c_DATA_WIDTH-1:0]  rd_data,
    output logic                     rd_last,
    output logic                     rd_empty,
    output logic                     almost_empty,
    output logic [c_DEPTH_WIDTH:0]   rd_water_level,
    output logic [c_DEPTH_WIDTH:0]   rd_pkt_cnt
);

    localparam int          AW       = c_DEPTH_WIDTH;
    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] ONE      = 1;
    localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};
    localparam int unsigned AF_NUM   = c_ALMOST_FULL_NUM;
    localparam int unsigned AE_NUM   = c_ALMOST_EMPTY_NUM;

    logic [c_DATA_WIDTH:0]   mem_q [0:DEPTH-1];

    logic [AW:0]             wp_tmp_q, wp_tmp_d;
    logic [AW:0]             rp_q, rp_d;
    logic [AW:0]             pkt_cnt_q, pkt_cnt_d;
    logic [c_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                    rd_last_q, rd_last_d;
    logic                    ovf_drop_q, ovf_drop_d;

    logic [AW:0]             wp_rd;
    logic [AW:0]             wr_lvl;
    logic [AW:0]             rd_lvl;
    logic                    full;
    logic                    empty;
    logic                    wr_acc;
    logic                    rd_acc;
    logic                    push_last;
    logic                    pop_last;
    logic [c_DATA_WIDTH:0]   rd_word;

    assign wr_lvl   = wp_tmp_q - rp_q;
    assign rd_lvl   = wp_rd - rp_q;
    assign full     = (wr_lvl == FULL_LVL);
    assign empty    = (rd_lvl == '0);
    assign rd_acc   = rd_en & ~empty;
    assign rd_word  = mem_q[rp_q[AW-1:0]];
    assign pop_last = rd_acc & rd_word[c_DATA_WIDTH];

`ifdef ETH_PKT_FIFO_STORE_FWD_EN
    logic [AW:0] wp_cmt_q, wp_cmt_d;
    logic        bad_q, bad_d;
    logic        ovf_evt;

    // Once a frame has overflowed, the rest of it is swallowed until its last word.
    assign wp_rd     = wp_cmt_q;
    assign ovf_evt   = wr_en & (full | bad_q);
    assign wr_acc    = wr_en & ~full & ~bad_q;
    assign push_last = wr_acc & wr_last & ~wr_drop;

    always_comb begin
        wp_tmp_d   = wp_tmp_q;
        wp_cmt_d   = wp_cmt_q;
        bad_d      = bad_q;
        ovf_drop_d = 1'b0;
        if (wr_drop) begin
            wp_tmp_d = wp_cmt_q;
            bad_d    = 1'b0;
        end else if (ovf_evt) begin
            if (wr_last) begin
                wp_tmp_d   = wp_cmt_q;
                bad_d      = 1'b0;
                ovf_drop_d = 1'b1;
            end else begin
                bad_d = 1'b1;
            end
        end else if (wr_acc) begin
            wp_tmp_d = wp_tmp_q + ONE;
            if (wr_last) begin
                wp_cmt_d = wp_tmp_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_cmt_q <= '0;
            bad_q    <= 1'b0;
        end else begin
            wp_cmt_q <= wp_cmt_d;
            bad_q    <= bad_d;
        end
    end
`else
    logic unused_wr_drop;

    // Cut-through: every accepted word is readable at once, nothing can be retracted.
    assign unused_wr_drop = wr_drop;
    assign wp_rd          = wp_tmp_q;
    assign wr_acc         = wr_en & ~full;
    assign push_last      = wr_acc & wr_last;

    always_comb begin
        wp_tmp_d   = wp_tmp_q;
        ovf_drop_d = 1'b0;
        if (wr_acc) begin
            wp_tmp_d = wp_tmp_q + ONE;
        end
    end
`endif

    always_comb begin
        rp_d      = rp_q;
        rd_data_d = rd_data_q;
        rd_last_d = rd_last_q;
        pkt_cnt_d = pkt_cnt_q;
        if (rd_acc) begin
            rp_d      = rp_q + ONE;
            rd_data_d = rd_word[c_DATA_WIDTH-1:0];
            rd_last_d = rd_word[c_DATA_WIDTH];
        end
        if (push_last && !pop_last) begin
            pkt_cnt_d = pkt_cnt_q + ONE;
        end else if (pop_last && !push_last) begin
            pkt_cnt_d = pkt_cnt_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wp_tmp_q[AW-1:0]] <= {wr_last, wr_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_tmp_q   <= '0;
            rp_q       <= '0;
            pkt_cnt_q  <= '0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            ovf_drop_q <= 1'b0;
        end else begin
            wp_tmp_q   <= wp_tmp_d;
            rp_q       <= rp_d;
            pkt_cnt_q  <= pkt_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_last_q  <= rd_last_d;
            ovf_drop_q <= ovf_drop_d;
        end
    end

    assign wr_full        = full;
    assign almost_full    = (32'(wr_lvl) >= AF_NUM);
    assign wr_water_level = wr_lvl;
    assign ovf_drop       = ovf_drop_q;
    assign rd_data        = rd_data_q;
    assign rd_last        = rd_last_q;
    assign rd_empty       = empty;
    assign almost_empty   = (32'(rd_lvl) <= AE_NUM);
    assign rd_water_level = rd_lvl;
    assign rd_pkt_cnt     = pkt_cnt_q;

endmodule

// File: doc/ipml_pkt_fifo_v1_0_eth.md
# ipml_pkt_fifo_v1_0_eth

Single-clock, parametrised packet FIFO for the Ethernet datapath, the next generation of the flat eth_fifo. Each stored word carries an end-of-frame flag. Frames become visible to the reader only once their last word is committed. A frame can be discarded mid-write, either explicitly or automatically on overflow. Sits between the MAC RX parser and the UDP/IP consumer so that downstream logic never sees a partial or corrupted frame.

## Interface
- c_DATA_WIDTH, 8, payload width per word (1–64)
- c_DEPTH_WIDTH, 11, log2 of entry count (4–14); depth D = 2^c_DEPTH_WIDTH
- c_ALMOST_FULL_NUM, 2040, almost_full threshold (wr_water_level ≥ value)
- c_ALMOST_EMPTY_NUM, 4, almost_empty threshold (rd_water_level ≤ value)
- clk  in  1  single clock for both sides
- rst  in  1  asynchronous, active-high reset
- wr_data  in  c_DATA_WIDTH  write payload
- wr_en  in  1  write request
- wr_last  in  1  qualifies wr_en; marks the last word of a frame
- wr_drop  in  1  discards the current uncommitted frame
- wr_full  out  1  write level == D
- almost_full  out  1  write level ≥ c_ALMOST_FULL_NUM
- wr_water_level  out  c_DEPTH_WIDTH+1  words stored, including uncommitted words
- ovf_drop  out  1  one-cycle pulse: a frame was auto-dropped after overflow
- rd_en  in  1  pop request
- rd_data  out  c_DATA_WIDTH  read payload
- rd_last  out  1  end-of-frame flag for rd_data
- rd_empty  out  1  no committed word is available
- almost_empty  out  1  rd_water_level ≤ c_ALMOST_EMPTY_NUM
- rd_water_level  out  c_DEPTH_WIDTH+1  committed words available to read
- rd_pkt_cnt  out  c_DEPTH_WIDTH+1  complete frames stored

## Operation
- **Storage:** simple dual-port RAM, D × (c_DATA_WIDTH+1). The extra bit holds the last flag.
- **Pointers:** wp_tmp, wp_cmt and rp, each c_DEPTH_WIDTH+1 bits. They wrap naturally; the MSB distinguishes full from empty.
- **Accepted write:** wr_en & !wr_full. It stores {wr_last, wr_data} at wp_tmp and increments wp_tmp.
- **Commit:** an accepted write with wr_last=1 sets wp_cmt ← wp_tmp+1 and increments rd_pkt_cnt.
- **Drop:** wr_drop=1 sets wp_tmp ← wp_cmt and clears the bad flag. When wr_drop and an accepted wr_last occur together, drop wins and nothing is committed.
- **Overflow:** wr_en while wr_full discards the word and sets bad.
  - Further words of that frame are discarded.
  - On the frame's wr_last (accepted or not): wp_tmp ← wp_cmt, bad cleared, ovf_drop pulses, no commit.
- **Accepted read:** rd_en & !rd_empty. It registers RAM[rp] onto {rd_last, rd_data} and increments rp.
  - If the popped word has last=1, rd_pkt_cnt decrements.
  - A simultaneous commit and last-pop leaves rd_pkt_cnt unchanged.
- **Levels:** wr_water_level = wp_tmp − rp; rd_water_level = wp_cmt − rp.
- **Flags:** decoded combinationally from registered pointers.
  - wr_full = (wr_water_level == D)
  - rd_empty = (rd_water_level == 0)
- **Ignored requests:** rd_en while rd_empty and wr_en while full change no pointer. rd_data and rd_last hold their values.

## Timing
- **Reset values** (asserted asynchronously):
  - pointers, bad, rd_pkt_cnt and both levels = 0
  - rd_data = 0, rd_last = 0, ovf_drop = 0
  - wr_full = 0, almost_full = 0
  - rd_empty = 1, almost_empty = 1
- **Reset mid-frame:** the partial frame is lost and no ovf_drop pulse is generated.
- **Read latency:** 1 cycle. rd_data is valid from the edge that accepts rd_en and holds until the next accepted read.
- **Commit visibility:** after a commit at edge N, rd_empty falls and rd_pkt_cnt updates after edge N (zero added latency).
- **Back-to-back:** full throughput, one write plus one read per cycle.
- **Word freed by a read at edge N:** writable from cycle N+1.
- **ovf_drop:** high for exactly the cycle after the edge that consumes the bad frame's wr_last.

## Configuration
- Macro: ETH_PKT_FIFO_STORE_FWD_EN.
- **Defined:** store-and-forward behaviour as described above.
- **Undefined:** cut-through mode.
  - Every accepted word is immediately readable: the read side uses wp_tmp and wp_cmt is removed.
  - wr_drop is ignored; ovf_drop is tied to 0; writes while full are simply discarded.
  - rd_pkt_cnt still counts stored last flags.

## Test plan
Bench configuration: c_DEPTH_WIDTH=4, c_DATA_WIDTH=8.
- **Reset:** assert rst mid-frame → all outputs take their reset values; rd_empty=1 and rd_pkt_cnt=0 within the same cycle.
- **Single frame:** write 0x01..0x05 with last on 0x05 → rd_empty stays 1 until after the 5th edge, then rd_pkt_cnt=1 and rd_water_level=5. Five reads → 01..05 with rd_last=1 only on 05; afterwards rd_pkt_cnt=0 and rd_empty=1.
- **Explicit drop:** write 3 words, then wr_drop → wr_water_level returns to 0, rd_empty stays 1, the next frame's data reads back cleanly.
- **Overflow:** write a 20-word frame → wr_full=1 after 16 writes; on the last word ovf_drop pulses once and wr_water_level=0. A following 2-word frame is read intact.
- **Simultaneous events:** wr_last commit at the same edge as popping the previous frame's last word → rd_pkt_cnt unchanged at 1. wr_last together with wr_drop → no commit.
- **Macro undefined:** write 3 words without last → rd_empty=0 after the first edge; wr_drop has no effect; a 20-word burst stores 16 words with ovf_drop=0.
